// File: rtl/ext_pkg.sv
// Shared mode encodings and the legal-mode predicate for the immediate extender.
package ext_pkg;

    localparam int unsigned EXT_ZERO      = 0;
    localparam int unsigned EXT_SIGN      = 1;
    localparam int unsigned EXT_LUI       = 2;
    localparam int unsigned EXT_SIGN_SHL2 = 3;

    function automatic logic ext_mode_legal(input int unsigned mode);
        return (mode <= EXT_SIGN_SHL2);
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: (imm, mode) -> (data, err).
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int MODE_W = 3
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  data,
    output logic              err
);

    logic [OUT_W-1:0] sext;

    always_comb begin
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        data = '0;
        err  = 1'b0;
        if (!ext_mode_legal(32'(mode))) begin
            err = 1'b1;
        end else begin
            case (32'(mode))
                EXT_ZERO:      data = {{(OUT_W-IN_W){1'b0}}, imm};
                EXT_SIGN:      data = sext;
                EXT_LUI:       data = {imm, {(OUT_W-IN_W){1'b0}}};
                // Shifting drops the top two sign copies; OUT_W >= IN_W+2 keeps the value intact.
                EXT_SIGN_SHL2: data = {sext[OUT_W-3:0], 2'b00};
                default:       data = '0;
            endcase
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: extension at accept time, main register M plus
// a one-entry skid register S so in_ready depends on registered state only.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int TAG_W  = 32,
    parameter int MODE_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [1:0]        occupancy
);

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .MODE_W(MODE_W)) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data),
        .err  (ext_err)
    );

    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [OUT_W-1:0] m_data_q,  m_data_d,  s_data_q,  s_data_d;
    logic [TAG_W-1:0] m_tag_q,   m_tag_d,   s_tag_q,   s_tag_d;
    logic             m_err_q,   m_err_d,   s_err_q,   s_err_d;
    logic             accept, xfer;

    assign in_ready  = !s_valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign xfer      = m_valid_q && out_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_tag   = m_tag_q;
    assign out_err   = m_err_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_tag_d   = m_tag_q;
        m_err_d   = m_err_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        s_err_d   = s_err_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_tag_d   = '0;
            m_err_d   = 1'b0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_tag_d   = '0;
            s_err_d   = 1'b0;
        end else if (!m_valid_q || (xfer && !s_valid_q)) begin
            // M free this edge: take the new item or go empty.
            m_valid_d = accept;
            if (accept) begin
                m_data_d = ext_data;
                m_tag_d  = in_tag;
                m_err_d  = ext_err;
            end
        end else if (!xfer) begin
            if (accept) begin
                s_valid_d = 1'b1;
                s_data_d  = ext_data;
                s_tag_d   = in_tag;
                s_err_d   = ext_err;
            end
        end else begin
            m_data_d  = s_data_q;
            m_tag_d   = s_tag_q;
            m_err_d   = s_err_q;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_tag_q   <= '0;
            m_err_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_tag_q   <= '0;
            s_err_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_tag_q   <= m_tag_d;
            m_err_q   <= m_err_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_tag_q   <= s_tag_d;
            s_err_q   <= s_err_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: modes, back-pressure, throughput, flush, reset, narrow instance.
module tb_ext_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_tag;
    logic        out_err;
    logic [1:0]  occupancy;

    logic        p_in_valid, p_in_ready, p_out_valid, p_out_err;
    logic [7:0]  p_imm, p_tag, p_out_tag;
    logic [2:0]  p_mode;
    logic [15:0] p_out_data;
    logic [1:0]  p_occ;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    ext_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .occupancy(occupancy)
    );

    ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(8), .MODE_W(3)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .flush(1'b0),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_imm),
        .in_mode(p_mode), .in_tag(p_tag),
        .out_valid(p_out_valid), .out_ready(1'b1), .out_data(p_out_data),
        .out_tag(p_out_tag), .out_err(p_out_err), .occupancy(p_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tx;
        int rx;
        int low_streak;
        int max_low;
        logic acc;

        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0;
        in_mode = '0; in_tag = '0; out_ready = 1'b1;
        p_in_valid = 1'b0; p_imm = '0; p_mode = '0; p_tag = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        #4 reset_n = 1'b1;
        tick();

        // One item per mode, back-to-back, out_ready high
        in_valid = 1'b1; in_imm = 16'h8001; in_mode = 3'd0; in_tag = 32'h100;
        tick();
        check("zero_valid", out_valid, 1);
        check("zero_data", out_data, 32'h0000_8001);
        check("zero_tag", out_tag, 32'h100);
        check("zero_err", out_err, 0);
        in_mode = 3'd1; in_tag = 32'h101;
        tick();
        check("sign_data", out_data, 32'hFFFF_8001);
        check("sign_tag", out_tag, 32'h101);
        in_mode = 3'd2; in_tag = 32'h102;
        tick();
        check("lui_data", out_data, 32'h8001_0000);
        check("lui_tag", out_tag, 32'h102);
        in_mode = 3'd3; in_tag = 32'h103;
        tick();
        check("shl2_data", out_data, 32'hFFFE_0004);
        check("shl2_err", out_err, 0);
        in_mode = 3'd5; in_tag = 32'h104;
        tick();
        check("illegal_data", out_data, 0);
        check("illegal_err", out_err, 1);
        check("illegal_tag", out_tag, 32'h104);
        in_valid = 1'b0;
        tick();
        check("modes_drained", out_valid, 0);

        // Back-pressure: tags 1..5 with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0;
        in_imm = 16'd1; in_tag = 32'd1;
        tick();
        check("bp_occ1", occupancy, 1);
        check("bp_ready1", in_ready, 1);
        in_imm = 16'd2; in_tag = 32'd2;
        tick();
        check("bp_occ2", occupancy, 2);
        check("bp_ready_low", in_ready, 0);
        check("bp_tag_hold1", out_tag, 1);
        in_imm = 16'd3; in_tag = 32'd3;
        tick();
        check("bp_occ2_hold", occupancy, 2);
        check("bp_tag_hold2", out_tag, 1);
        check("bp_data_hold", out_data, 1);
        out_ready = 1'b1;
        tick();
        check("bp_drain2", out_tag, 2);
        check("bp_occ_after", occupancy, 1);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_drain3", out_tag, 3);
        in_imm = 16'd4; in_tag = 32'd4;
        tick();
        check("bp_drain4", out_tag, 4);
        in_imm = 16'd5; in_tag = 32'd5;
        tick();
        check("bp_drain5", out_tag, 5);
        check("bp_data5", out_data, 5);
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // Throughput: out_ready toggling, continuous input stream
        tx = 0; rx = 0; low_streak = 0; max_low = 0;
        for (int cyc = 0; cyc < 40 && rx < 10; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (tx < 10);
            in_imm    = 16'(tx);
            in_mode   = 3'd0;
            in_tag    = 32'h500 + 32'(tx);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("tp_tag", out_tag, 32'h500 + 32'(rx));
                check("tp_data", out_data, 64'(rx));
                rx++;
            end
            if (!in_ready) low_streak++;
            else low_streak = 0;
            if (low_streak > max_low) max_low = low_streak;
            tick();
            if (acc) tx++;
        end
        in_valid = 1'b0;
        check("tp_count", 64'(rx), 10);
        check("tp_ready_low_max1", 64'(max_low <= 1), 1);

        // Flush with two items buffered and an input offered
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0201; in_tag = 32'h201;
        tick();
        in_imm = 16'h0202; in_tag = 32'h202;
        tick();
        check("fl_pre_occ", occupancy, 2);
        flush = 1'b1; in_imm = 16'h02FF; in_tag = 32'h2FF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_occ", occupancy, 0);
        check("fl_ready", in_ready, 1);
        check("fl_data_zero", out_data, 0);
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", out_valid, 0);

        // Asynchronous reset between edges with an item held
        out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h1234; in_mode = 3'd0; in_tag = 32'h301;
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_data", out_data, 0);
        check("ar_tag", out_tag, 0);
        check("ar_occ", occupancy, 0);
        check("ar_ready", in_ready, 1);
        tick();
        reset_n = 1'b1;
        in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 3'd1; in_tag = 32'h400; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ar_first_valid", out_valid, 1);
        check("ar_first_data", out_data, 32'h0000_7FFF);
        check("ar_first_tag", out_tag, 32'h400);

        // Narrow instance IN_W=8, OUT_W=16
        p_in_valid = 1'b1; p_imm = 8'h80; p_mode = 3'd1; p_tag = 8'h11;
        tick();
        check("n_sign", p_out_data, 16'hFF80);
        check("n_sign_tag", p_out_tag, 8'h11);
        p_mode = 3'd2;
        tick();
        check("n_lui", p_out_data, 16'h8000);
        p_mode = 3'd3;
        tick();
        check("n_shl2", p_out_data, 16'hFE00);
        p_in_valid = 1'b0;
        tick();
        check("n_empty", p_out_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the pipelined datapath; successor to the single-cycle combinational extender.
- Takes an IN_W-bit immediate with a mode code and a tag (normally the instruction PC).
- Produces an OUT_W-bit extended value one cycle later through a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput under back-pressure; flush supports branch/exception squash.

Parameters:
- IN_W, 16, immediate width; must satisfy OUT_W >= IN_W+2.
- OUT_W, 32, extended result width.
- TAG_W, 32, width of sideband tag carried with each item.
- MODE_W, 3, width of mode code.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all buffered items
- in_valid  in  1  input item present
- in_ready  out  1  unit can accept an item this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  MODE_W  extension mode
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output item present
- out_ready  in  1  consumer accepts output this cycle
- out_data  out  OUT_W  extended result
- out_tag  out  TAG_W  tag of the output item
- out_err  out  1  output item had an illegal mode
- occupancy  out  2  number of buffered items (0..2)

Behaviour:
- Modes:
  - 0 ZERO: zero-extend.
  - 1 SIGN: sign-extend from in_imm[IN_W-1].
  - 2 LUI: imm placed in bits [OUT_W-1:OUT_W-IN_W], low bits zero.
  - 3 SIGN_SHL2: sign-extend, then shift left 2, keeping low OUT_W bits.
  - 4..7: illegal; data = 0, err = 1.
- Extension is computed at accept time; the stored entry holds data, tag and err.
- Storage: main register M drives the out_* ports; skid register S.
- in_ready = !S.valid (registered state only; no combinational path from out_ready).
- Accept = in_valid && in_ready && !flush. Transfer = out_valid && out_ready.
- Next-state per edge:
  - If M is empty, or M is transferring with S empty: an accepted item loads M.
  - If M is held (valid, not transferring): an accepted item loads S.
  - If M is transferring and S is full: S moves to M and S clears. No accept is possible in this case because in_ready = 0.
  - If M is transferring, S is empty and there is no accept: M clears.
- Latency: 1 cycle from accept to out_valid when M is empty. Throughput is 1 item/cycle while out_ready = 1.
- Order is strictly FIFO; no item is dropped or duplicated.
- While out_valid && !out_ready, out_data, out_tag and out_err are stable.
- flush = 1 at an edge: M and S invalidated; same-cycle input is not accepted; a same-cycle transfer still counts as consumed by the consumer. Next cycle: in_ready = 1, occupancy = 0.
- Reset (async assert, sync release):
  - out_valid = 0, out_data = 0, out_tag = 0, out_err = 0.
  - occupancy = 0, in_ready = 1.
  - Reset mid-stream discards all items.
- occupancy = M.valid + S.valid.
- When out_valid = 0, the out_data/out_tag/out_err values are don't-care. The implementation zeroes them on flush and reset.

Decomposition:
- Package ext_pkg: mode constants EXT_ZERO = 0, EXT_SIGN = 1, EXT_LUI = 2, EXT_SIGN_SHL2 = 3, and a function/constant for the legal-mode check.
- Sub-module ext_core: purely combinational (imm, mode) -> (data, err), parametrised on IN_W/OUT_W. It is instantiated once at the input; ext_pipe holds the handshake and skid logic.

Test Plan:
- Modes, out_ready = 1, one item each:
  - imm 0x8001, ZERO -> 0x00008001.
  - SIGN -> 0xFFFF8001.
  - LUI -> 0x80010000.
  - SIGN_SHL2 -> 0xFFFE0004.
  - mode 5 -> data 0, err = 1.
  - Each appears 1 cycle after accept with the matching tag.
- Back-pressure: stream tags 1..5 with out_ready = 0:
  - Occupancy reaches 2 and in_ready drops after the 2nd accept.
  - out_tag stays 1 and stable.
  - Raising out_ready drains 1..5 in order with no loss.
- Throughput: out_ready toggling 1/0 every cycle with a continuous input stream -> all items delivered in order; in_ready never low for more than 1 cycle.
- Flush with occupancy = 2 and in_valid = 1 -> next cycle out_valid = 0, occupancy = 0, in_ready = 1; the flushed-cycle input never appears at the output.
- Async reset asserted mid-stream, between clock edges -> outputs clear immediately. After release the first new item (imm 0x7FFF, SIGN) emerges as 0x00007FFF.
- Parametrised instance IN_W = 8, OUT_W = 16: imm 0x80, SIGN -> 0xFF80; LUI -> 0x8000; SIGN_SHL2 -> 0xFE00.
